systolic_deskew: RTL

- Receive-side counterpart of the input skew delay lines that feed the systolic array.
- Accepts a multi-lane result bus whose lanes arrive staggered: lane i is i cycles later than lane 0.
- Realigns the lanes into one vector with a single valid, counts rows per frame, and flags misaligned rows.
- Sits between the array's output edge and the result writeback logic.

---
 rtl/deskew_pkg.sv | 21 ++
 rtl/deskew_lane.sv | 36 +++
 rtl/systolic_deskew.sv | 69 ++++++
 3 files changed

// File: rtl/deskew_pkg.sv
// Shared constants and helpers for the systolic array output deskew block.
package deskew_pkg;

  localparam int unsigned DATA_SIZE = 16;
  localparam int unsigned SIZE      = 4;
  localparam int unsigned ROWS      = 4;

  // Width of a counter that must hold 0..n_rows
  function automatic int unsigned row_cnt_width(input int unsigned n_rows);
    return $clog2(n_rows + 1);
  endfunction

  localparam int unsigned ROW_CNT_W = row_cnt_width(ROWS);

  // Bit offset of a lane inside the packed bus
  function automatic int unsigned lane_slice(input int unsigned index,
                                             input int unsigned width = DATA_SIZE);
    return index * width;
  endfunction

endpackage

// File: rtl/deskew_lane.sv
// One lane of the deskew: a resettable {valid, data} shift register of configurable depth.
module deskew_lane #(
  parameter int unsigned depth = 0,
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] data_in,
  input  logic             valid_in,
  output logic [width-1:0] data_out,
  output logic             valid_out
);

  if (depth == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign data_out  = data_in;
    assign valid_out = valid_in;
  end else begin : g_shift
    // Valid rides in the MSB so data and valid always move together
    logic [width:0] pipe [depth];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < int'(depth); k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= {valid_in, data_in};
        for (int k = 1; k < int'(depth); k++) pipe[k] <= pipe[k-1];
      end
    end

    assign valid_out = pipe[depth-1][width];
    assign data_out  = pipe[depth-1][width-1:0];
  end

endmodule

// File: rtl/systolic_deskew.sv
// Realigns the staggered lanes leaving the systolic array into one valid row,
// counts rows per frame and flags rows whose lanes do not line up.
module systolic_deskew
  import deskew_pkg::*;
#(
  parameter int unsigned data_size = DATA_SIZE,
  parameter int unsigned size      = SIZE,
  parameter int unsigned rows      = ROWS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [data_size*size-1:0]         bus_in,
  input  logic [size-1:0]                   valid_in,
  output logic [data_size*size-1:0]         bus_out,
  output logic                              valid_out,
  output logic [row_cnt_width(rows)-1:0]    row_count,
  output logic                              frame_done,
  output logic                              skew_error
);

  localparam int unsigned CW = row_cnt_width(rows);
  localparam int unsigned BW = data_size * size;

  logic [size-1:0] av;
  logic [BW-1:0]   aligned;

  // Lane i is delayed size-1-i cycles so every lane reaches the output register together
  for (genvar i = 0; i < int'(size); i++) begin : g_lane
    localparam int unsigned OFS = lane_slice(i, data_size);
    deskew_lane #(
      .depth (size - 1 - i),
      .width (data_size)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .data_in   (bus_in[OFS +: data_size]),
      .valid_in  (valid_in[i]),
      .data_out  (aligned[OFS +: data_size]),
      .valid_out (av[i])
    );
  end

  // Output register: only fully valid rows are accepted, partial rows are dropped and flagged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_out    <= '0;
      valid_out  <= 1'b0;
      row_count  <= '0;
      frame_done <= 1'b0;
      skew_error <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (&av) begin
        bus_out   <= aligned;
        valid_out <= 1'b1;
        if (row_count == CW'(rows - 1)) begin
          row_count  <= '0;
          frame_done <= 1'b1;
        end else begin
          row_count <= row_count + CW'(1);
        end
      end else if (|av) begin
        skew_error <= 1'b1;
      end
    end
  end

endmodule
